goomba_ctrl: RTL

Per-enemy controller that sequences one goomba through spawn, walking, squished and removed states, and drives the shared 21x21 goomba sprite ROMs. Each VGA pixel it produces a registered ROM read address, a sprite-select code and an in-sprite flag. The colour mapper uses these to pick the walking or squished ROM and to treat palette index 0 (0x800080) as transparent. Game logic drives it with frame ticks, spawn and stomp events; one instance exists per on-screen goomba.

---
 rtl/goomba_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/goomba_ctrl.sv
// goomba_ctrl
// Sequences one goomba through IDLE -> WALK -> SQUISH -> IDLE and produces a
// registered per-pixel sprite ROM address for the shared 21x21 goomba art.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   frame_tick            one-cycle pulse per video frame
//   spawn, spawn_x/_y     start a goomba at the given top-left position
//   stomp                 Mario landed on this goomba
//   DrawX, DrawY          current VGA pixel
//   read_address          registered sprite ROM address (row-major, 0..440)
//   sprite_sel            registered: 0 none, 1 walk A, 2 walk B, 3 squished
//   in_sprite             registered: pixel lies inside an active goomba
//   goomba_x, goomba_y    current top-left position
//   state                 0 IDLE, 1 WALK, 2 SQUISH
//   active                state != IDLE
module goomba_ctrl #(
    parameter int SPRITE_W      = 21,
    parameter int SPRITE_H      = 21,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 619,
    parameter int SPEED         = 1,
    parameter int SQUISH_FRAMES = 30,
    parameter int ANIM_FRAMES   = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       spawn,
    input  logic [9:0] spawn_x,
    input  logic [9:0] spawn_y,
    input  logic       stomp,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [8:0] read_address,
    output logic [1:0] sprite_sel,
    output logic       in_sprite,
    output logic [9:0] goomba_x,
    output logic [9:0] goomba_y,
    output logic [1:0] state,
    output logic       active
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WALK   = 2'd1,
        S_SQUISH = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       dir_right;     // 0 = moving left (ROM art orientation)
    logic       anim_bit;
    logic [7:0] anim_cnt;
    logic [7:0] squish_cnt;

    // Pixel-path combinational results, registered below.
    logic signed [10:0] rx, ry;
    logic               hit;
    logic [4:0]         col;     // sprite is at most 32 pixels wide
    logic [8:0]         addr_d;
    logic [1:0]         sel_d;

    // Movement candidates, one bit wider than position so edges never wrap.
    logic [10:0] x_left, x_right;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (spawn) state_d = S_WALK;
            S_WALK:   if (stomp) state_d = S_SQUISH;
            S_SQUISH: if (frame_tick && squish_cnt == 8'd1) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        state  = state_q;
        active = (state_q != S_IDLE);

        rx  = signed'({1'b0, DrawX}) - signed'({1'b0, goomba_x});
        ry  = signed'({1'b0, DrawY}) - signed'({1'b0, goomba_y});
        hit = active
              && rx >= 11'sd0 && rx < signed'(11'(SPRITE_W))
              && ry >= 11'sd0 && ry < signed'(11'(SPRITE_H));

        // Art faces left; only a right-walking goomba is mirrored.
        if (state_q == S_WALK && dir_right) col = 5'(SPRITE_W - 1) - rx[4:0];
        else                                col = rx[4:0];

        addr_d = 9'(ry[4:0]) * 9'(SPRITE_W) + 9'(col);
        sel_d  = (state_q == S_SQUISH) ? 2'd3 : ({1'b0, anim_bit} + 2'd1);

        if (!hit) begin
            addr_d = 9'd0;
            sel_d  = 2'd0;
        end
    end

    // ------------------------------------------------------- datapath
    always_comb begin
        x_left  = {1'b0, goomba_x} - 11'(SPEED);
        x_right = {1'b0, goomba_x} + 11'(SPEED);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            goomba_x     <= '0;
            goomba_y     <= '0;
            dir_right    <= 1'b0;
            anim_bit     <= 1'b0;
            anim_cnt     <= '0;
            squish_cnt   <= '0;
            read_address <= '0;
            sprite_sel   <= '0;
            in_sprite    <= 1'b0;
        end else begin
            read_address <= addr_d;
            sprite_sel   <= sel_d;
            in_sprite    <= hit;

            unique case (state_q)
                S_IDLE: begin
                    if (spawn) begin
                        goomba_x  <= spawn_x;
                        goomba_y  <= spawn_y;
                        dir_right <= 1'b0;
                        anim_bit  <= 1'b0;
                        anim_cnt  <= '0;
                    end
                end
                S_WALK: begin
                    // Stomp wins over a coincident frame tick: no movement.
                    if (stomp) begin
                        squish_cnt <= 8'(SQUISH_FRAMES);
                    end else if (frame_tick) begin
                        if (!dir_right) begin
                            // Signed compare catches x - SPEED going negative.
                            if ($signed(x_left) < $signed(11'(X_MIN))) begin
                                goomba_x  <= 10'(X_MIN);
                                dir_right <= 1'b1;
                            end else begin
                                goomba_x  <= x_left[9:0];
                            end
                        end else begin
                            if (x_right > 11'(X_MAX)) begin
                                goomba_x  <= 10'(X_MAX);
                                dir_right <= 1'b0;
                            end else begin
                                goomba_x  <= x_right[9:0];
                            end
                        end

                        if (anim_cnt == 8'(ANIM_FRAMES - 1)) begin
                            anim_cnt <= '0;
                            anim_bit <= ~anim_bit;
                        end else begin
                            anim_cnt <= anim_cnt + 8'd1;
                        end
                    end
                end
                S_SQUISH: begin
                    if (frame_tick) squish_cnt <= squish_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
